// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle for alu_share_arbiter.
// slave is the arbiter's view; master is the requesters/ALU/consumer side.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [2:0]       req0_f;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [2:0]       req1_f;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_f;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_overflow;
   logic             alu_carry;
   logic             alu_negative;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_overflow;
   logic             rsp_carry;
   logic             rsp_negative;
   logic             rsp_err;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_f,
      input  req1_valid, req1_a, req1_b, req1_f,
      input  alu_result, alu_zero, alu_overflow, alu_carry, alu_negative,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_f,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow,
      output rsp_carry, rsp_negative, rsp_err, busy, op_count
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_f,
      output req1_valid, req1_a, req1_b, req1_f,
      output alu_result, alu_zero, alu_overflow, alu_carry, alu_negative,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_f,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow,
      input  rsp_carry, rsp_negative, rsp_err, busy, op_count
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters;
// one op in flight, IDLE -> EXEC -> RESP, tagged response with error suppression.
module alu_share_arbiter #(
   parameter int         WIDTH   = 32,
   parameter logic [7:0] LEGAL_F = 8'b0010_1111,
   parameter int         CNT_W   = 16
) (
   input logic                clk,
   input logic                reset_n,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             last_grant;
   logic             id_p1;
   logic             err_p1;
   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       sel_f;

   function automatic logic illegal_f(input logic [2:0] f);
      return ~LEGAL_F[f];
   endfunction

   // A lone requester always wins; on contention the one not served last wins.
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
      sel_a  = grant1 ? bus.req1_a : bus.req0_a;
      sel_b  = grant1 ? bus.req1_b : bus.req0_b;
      sel_f  = grant1 ? bus.req1_f : bus.req0_f;
   end

   assign bus.req0_ready = (state == IDLE) & grant0;
   assign bus.req1_ready = (state == IDLE) & grant1;
   assign bus.busy       = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         id_p1            <= 1'b0;
         err_p1           <= 1'b0;
         bus.alu_a        <= '0;
         bus.alu_b        <= '0;
         bus.alu_f        <= '0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_id       <= 1'b0;
         bus.rsp_result   <= '0;
         bus.rsp_zero     <= 1'b0;
         bus.rsp_overflow <= 1'b0;
         bus.rsp_carry    <= 1'b0;
         bus.rsp_negative <= 1'b0;
         bus.rsp_err      <= 1'b0;
         bus.op_count     <= '0;
      end else begin
         case (state)
            // Accept: operands go to the ALU unmodified, even for illegal f.
            IDLE: begin
               if (grant0 | grant1) begin
                  bus.alu_a  <= sel_a;
                  bus.alu_b  <= sel_b;
                  bus.alu_f  <= sel_f;
                  id_p1      <= grant1;
                  err_p1     <= illegal_f(sel_f);
                  last_grant <= grant1;
                  state      <= EXEC;
               end
            end
            // ALU has settled for one cycle; capture or suppress its outputs.
            EXEC: begin
               bus.rsp_valid <= 1'b1;
               bus.rsp_id    <= id_p1;
               bus.rsp_err   <= err_p1;
               if (err_p1) begin
                  bus.rsp_result   <= '0;
                  bus.rsp_zero     <= 1'b0;
                  bus.rsp_overflow <= 1'b0;
                  bus.rsp_carry    <= 1'b0;
                  bus.rsp_negative <= 1'b0;
               end else begin
                  bus.rsp_result   <= bus.alu_result;
                  bus.rsp_zero     <= bus.alu_zero;
                  bus.rsp_overflow <= bus.alu_overflow;
                  bus.rsp_carry    <= bus.alu_carry;
                  bus.rsp_negative <= bus.alu_negative;
               end
               state <= RESP;
            end
            // Response data stays put after the handshake; only valid drops.
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.op_count  <= bus.op_count + CNT_W'(1);
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
